piso_stream: RTL and testbench
==============================

# piso_stream

Parametrised parallel-in/serial-out word serialiser with valid/ready handshakes on both the parallel load side and the serial output side. It accepts a frame of up to DEPTH words with a variable length and emits the words one per accepted beat, in either ascending or descending index order. The last word of each frame is flagged. A new frame can be loaded on the same cycle the previous frame's last word is taken, so back-to-back frames have no bubble. It sits between a block that produces word vectors and a narrow serial consumer that applies backpressure.

## Interface
Parameters:
- DATA_WID, 8, width of one word
- DEPTH, 5, maximum words per frame; must be ≥ 2
- CNT_W, $clog2(DEPTH+1), width of length and count fields

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- load_valid  in  1  a frame is offered on load_data/load_len/load_dir
- load_ready  out  1  the block can accept a frame this cycle
- load_data  in  DEPTH*DATA_WID  frame words, flattened; word i is bits [i*DATA_WID +: DATA_WID]
- load_len  in  CNT_W  number of valid words, starting at word 0
- load_dir  in  1  output order: 0 = word 0 first (ascending), 1 = word load_len-1 first (descending)
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  the consumer takes the word this cycle
- out_data  out  DATA_WID  current serial word
- out_last  out  1  current word is the final word of the frame
- busy  out  1  a frame is being emitted
- remaining  out  CNT_W  words still to be emitted, including the current one

## Operation
- States: IDLE and SHIFT.
- Frame storage: a DEPTH×DATA_WID register array.
- Frame registers: a read pointer ptr, a count rem, and the latched direction dir.
- Load acceptance: a load is accepted when load_valid && load_ready at a clock edge.
- load_ready = (state==IDLE) || (out_valid && out_ready && out_last).
  - This is the only combinational input-to-output path.
- On an accepted load:
  - Capture all DEPTH words into the array.
  - Set len_eff = min(load_len, DEPTH). Larger values are clamped to DEPTH.
  - Set rem = len_eff.
  - Set dir = load_dir.
  - Set ptr = 0 if dir==0, else len_eff-1.
  - Go to SHIFT.
- Zero-length load (load_len==0): accepted (handshake completes) and discarded.
  - In IDLE: stay in IDLE.
  - On a last beat: go to IDLE.
- SHIFT outputs:
  - out_valid=1
  - out_data=mem[ptr]
  - out_last=(rem==1)
- Beat in SHIFT (out_ready=1):
  - Not last: rem decrements; ptr increments if dir==0, decrements if dir==1.
  - Last, with a load accepted the same cycle: reload per the load rules above and stay in SHIFT (or go to IDLE for len 0).
  - Last, with no load: go to IDLE.
- Stall (out_valid && !out_ready): out_data, out_last, rem and ptr hold stable until the beat completes.
- IDLE outputs: out_valid=0, out_data=0, out_last=0, busy=0, remaining=0.
- busy = (state==SHIFT).
- remaining = rem in SHIFT, 0 in IDLE.
- load_data/load_len/load_dir are ignored unless the load is accepted.
- Reset assertion at any time, including mid-frame:
  - Takes effect immediately: state=IDLE, array cleared to 0, rem=0, ptr=0.
  - The in-flight frame is lost.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, busy=0, remaining=0.
- load_ready is 1 whenever rst_n is high and the state is IDLE.
- Loads presented while rst_n is low are not captured.
- Load to first word: load accepted at edge N → out_valid=1 with the first word during cycle N+1 (1-cycle latency).
- Throughput: with out_ready held high, one word per cycle; a frame of L words occupies L cycles.
- Back-to-back frames: the last beat and the next load share the same edge, so the first word of the new frame appears the next cycle with no idle cycle.
- Frames loaded while in SHIFT are not accepted except on the last beat; load_ready is 0 otherwise.

## Test plan
All scenarios use DATA_WID=8, DEPTH=5.
- Reset: pulse rst_n low mid-cycle with clk stopped → outputs go to 0 immediately, load_ready=1 after release.
- Ascending frame: words {0x11,0x22,0x33,0x44,0x55}, len=5, dir=0, out_ready=1 → out_data 0x11,0x22,0x33,0x44,0x55 on cycles N+1..N+5; out_last only with 0x55; remaining 5,4,3,2,1; then out_valid=0.
- Descending short frame with backpressure: same words, len=3, dir=1; out_ready pattern 1,0,0,1,1 → words 0x33,0x22(held 3 cycles),0x11, with out_last on 0x11; stalled words stay stable.
- Back-to-back frames: frame A (len=2: 0xA0,0xA1, dir=0) then frame B (len=1: 0xB0) presented with load_valid held → 0xA0,0xA1,0xB0 on consecutive cycles; load_ready=1 only in IDLE and on the 0xA1 beat.
- Length edge cases:
  - load_len=0 → handshake completes, out_valid stays 0.
  - load_len=7 → clamped to 5 words, remaining starts at 5.
- Mid-frame reset: assert rst_n after 2 of 5 words → out_valid=0 immediately; after release, a new frame 0x01..0x05 emits cleanly with no residue from the old frame.

Source files
------------

// File: rtl/piso_stream_if.sv
// piso_stream_if: handshake bundle for the piso_stream serialiser.
//   load side : load_valid/load_ready, load_data (DEPTH words flattened,
//               word i at [i*DATA_WID +: DATA_WID]), load_len, load_dir
//   out side  : out_valid/out_ready, out_data, out_last
//   status    : busy, remaining
// master = frame producer / serial consumer side, slave = the serialiser.
interface piso_stream_if #(
  parameter int DATA_WID = 8,
  parameter int DEPTH    = 5,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) ();
  logic                      load_valid;
  logic                      load_ready;
  logic [DEPTH*DATA_WID-1:0] load_data;
  logic [CNT_W-1:0]          load_len;
  logic                      load_dir;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WID-1:0]       out_data;
  logic                      out_last;
  logic                      busy;
  logic [CNT_W-1:0]          remaining;

  modport master (
    output load_valid, load_data, load_len, load_dir, out_ready,
    input  load_ready, out_valid, out_data, out_last, busy, remaining
  );

  modport slave (
    input  load_valid, load_data, load_len, load_dir, out_ready,
    output load_ready, out_valid, out_data, out_last, busy, remaining
  );
endinterface

// File: rtl/piso_stream.sv
// piso_stream: parallel-in/serial-out word serialiser.
// Accepts a frame of up to DEPTH words (length clamped to DEPTH, zero-length
// frames are accepted and dropped) and emits it one word per accepted beat,
// ascending or descending, flagging the last word. A new frame may load on
// the same edge the previous frame's last word is taken.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - piso_stream_if.slave (load handshake, serial handshake, status)
//
// state | meaning
// IDLE  | no frame held, load_ready=1, outputs zero
// SHIFT | emitting mem[ptr], rem words left including the current one
module piso_stream #(
  parameter int DATA_WID = 8,
  parameter int DEPTH    = 5,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  piso_stream_if.slave bus
);
  localparam int              PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_q, state_d;
  logic [DATA_WID-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                dir_q, dir_d;

  logic [CNT_W-1:0]    len_eff;
  logic [PTR_W-1:0]    ptr_start;
  logic                in_shift;
  logic                beat;
  logic                load_fire;
  logic                start;

  assign len_eff   = (bus.load_len > DEPTH_C) ? DEPTH_C : bus.load_len;
  // only meaningful when len_eff != 0, which is the only case it is used
  assign ptr_start = bus.load_dir ? PTR_W'(len_eff - ONE_C) : '0;

  assign in_shift      = (state_q == SHIFT);
  assign bus.out_valid = in_shift;
  assign bus.out_last  = in_shift && (rem_q == ONE_C);
  assign bus.out_data  = in_shift ? mem_q[ptr_q] : '0;
  assign bus.busy      = in_shift;
  assign bus.remaining = in_shift ? rem_q : '0;

  assign beat           = in_shift && bus.out_ready;
  // taking the last word frees the array on this very edge
  assign bus.load_ready = (state_q == IDLE) || (beat && bus.out_last);
  assign load_fire      = bus.load_valid && bus.load_ready;
  assign start          = load_fire && (len_eff != '0);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ptr_d   = ptr_q;
    dir_d   = dir_q;
    if (start) begin
      state_d = SHIFT;
      rem_d   = len_eff;
      dir_d   = bus.load_dir;
      ptr_d   = ptr_start;
    end else if (beat) begin
      if (bus.out_last) begin
        // covers both "no load" and a zero-length load on the last beat
        state_d = IDLE;
        rem_d   = '0;
        ptr_d   = '0;
      end else begin
        rem_d = rem_q - ONE_C;
        ptr_d = dir_q ? (ptr_q - PTR_W'(1)) : (ptr_q + PTR_W'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      ptr_q   <= '0;
      dir_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      dir_q   <= dir_d;
      if (start) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[i] <= bus.load_data[i*DATA_WID +: DATA_WID];
        end
      end
    end
  end
endmodule

// File: tb/tb_piso_stream.sv
// tb_piso_stream: self-checking bench for piso_stream (DATA_WID=8, DEPTH=5).
// A table of frames (inputs plus expected emission order) drives most of the
// run; accepted loads push expected words into a scoreboard queue and a
// monitor compares every presented word against the queue head. Hand-written
// sequences cover reset, mid-frame reset and back-to-back frames.
module tb_piso_stream;
  localparam int DATA_WID = 8;
  localparam int DEPTH    = 5;
  localparam int CNT_W    = $clog2(DEPTH + 1);

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  bit   clk_en = 1'b1;

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  piso_stream_if #(.DATA_WID(DATA_WID), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  piso_stream #(.DATA_WID(DATA_WID), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [39:0] data;
    logic [2:0]  len;
    logic        dir;
    logic [7:0]  rdy;    // out_ready pattern, bit k used on drain cycle k%8
    logic [3:0]  exp_n;  // words expected out
    logic [39:0] exp_w;  // expected words in emission order, first at [7:0]
  } frame_t;

  typedef struct packed {
    logic [7:0]       data;
    logic             last;
    logic [CNT_W-1:0] rem;
  } exp_t;

  frame_t      tbl [8];
  exp_t        sb [$];
  logic [39:0] pres_w = '0;
  int          pres_n = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: sampled on the falling edge, describing the coming rising edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          check("out_data", bus.out_data, sb[0].data);
          check("out_last", bus.out_last, sb[0].last);
          check("remaining", bus.remaining, sb[0].rem);
          if (bus.out_ready) void'(sb.pop_front());
        end
      end
      if (bus.load_valid && bus.load_ready) begin
        for (int k = 0; k < pres_n; k++) begin
          exp_t e;
          e.data = pres_w[k*8 +: 8];
          e.last = (k == pres_n - 1);
          e.rem  = 3'(pres_n - k);
          sb.push_back(e);
        end
      end
    end
  end

  task automatic present(input frame_t f);
    bus.load_data = f.data;
    bus.load_len  = f.len;
    bus.load_dir  = f.dir;
    pres_w        = f.exp_w;
    pres_n        = int'(f.exp_n);
  endtask

  task automatic run_frame(input frame_t f);
    int n;
    int k;
    @(posedge clk); #1;
    present(f);
    bus.load_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.load_ready && n < 20);
    check("load_accept", bus.load_ready, 1);
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    check("first_word_valid", bus.out_valid, (f.exp_n != 0));
    k = 0;
    while (sb.size() != 0 && k < 60) begin
      bus.out_ready = f.rdy[k%8];
      @(posedge clk); #1;
      k++;
    end
    check("drain_done", sb.size(), 0);
    check("idle_valid", bus.out_valid, 0);
    check("idle_busy", bus.busy, 0);
    check("idle_load_ready", bus.load_ready, 1);
    bus.out_ready = 1'b1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_out_last"}, bus.out_last, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_remaining"}, bus.remaining, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t fa;
    frame_t fb;
    tbl[0] = '{40'h5544332211, 3'd5, 1'b0, 8'hFF,        4'd5, 40'h5544332211};
    tbl[1] = '{40'h5544332211, 3'd3, 1'b1, 8'b11111001,  4'd3, 40'h0000112233};
    tbl[2] = '{40'h5544332211, 3'd7, 1'b0, 8'b10110111,  4'd5, 40'h5544332211};
    tbl[3] = '{40'h5544332211, 3'd7, 1'b1, 8'b10100101,  4'd5, 40'h1122334455};
    tbl[4] = '{40'h5544332211, 3'd0, 1'b0, 8'hFF,        4'd0, 40'h0};
    tbl[5] = '{40'h00000000C3, 3'd1, 1'b1, 8'b01101101,  4'd1, 40'h00000000C3};
    tbl[6] = '{40'h9901EFCDAB, 3'd4, 1'b1, 8'b11011011,  4'd4, 40'h00ABCDEF01};
    tbl[7] = '{40'h0504030201, 3'd6, 1'b0, 8'b11101111,  4'd5, 40'h0504030201};
    fa     = '{40'h000000A1A0, 3'd2, 1'b0, 8'hFF,        4'd2, 40'h000000A1A0};
    fb     = '{40'h00000000B0, 3'd1, 1'b0, 8'hFF,        4'd1, 40'h00000000B0};

    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_len   = '0;
    bus.load_dir   = 1'b0;
    bus.out_ready  = 1'b1;

    // power-on reset, with a load offered that must not be captured
    bus.load_valid = 1'b1;
    bus.load_len   = 3'd5;
    bus.load_data  = 40'hFFFFFFFFFF;
    repeat (2) @(negedge clk);
    check_zero_outputs("rst");
    #1;
    bus.load_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst_release_load_ready", bus.load_ready, 1);
    check_zero_outputs("post_rst");

    for (int i = 0; i < 8; i++) begin
      run_frame(tbl[i]);
    end

    // back-to-back: B offered while A is in flight, taken on A's last beat
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    present(fa);
    bus.load_valid = 1'b1;
    @(posedge clk); #1;
    present(fb);
    check("b2b_c1_valid", bus.out_valid, 1);
    check("b2b_c1_data", bus.out_data, 8'hA0);
    @(negedge clk);
    check("b2b_c1_load_ready", bus.load_ready, 0);
    @(posedge clk); #1;
    check("b2b_c2_data", bus.out_data, 8'hA1);
    check("b2b_c2_last", bus.out_last, 1);
    @(negedge clk);
    check("b2b_c2_load_ready", bus.load_ready, 1);
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    check("b2b_c3_valid", bus.out_valid, 1);
    check("b2b_c3_data", bus.out_data, 8'hB0);
    check("b2b_c3_last", bus.out_last, 1);
    @(posedge clk); #1;
    check("b2b_c4_valid", bus.out_valid, 0);
    check("b2b_c4_load_ready", bus.load_ready, 1);
    check("b2b_sb_empty", sb.size(), 0);

    // mid-frame reset with the clock stopped
    @(posedge clk); #1;
    present(tbl[0]);
    bus.load_valid = 1'b1;
    bus.out_ready  = 1'b1;
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_pre_rst_data", bus.out_data, 8'h33);
    check("mid_pre_rst_rem", bus.remaining, 3);
    @(negedge clk);
    clk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("mid_rst");
    sb.delete();
    #7;
    rst_n = 1'b1;
    #1;
    check("mid_rst_release_load_ready", bus.load_ready, 1);
    check_zero_outputs("mid_post_rst");
    clk_en = 1'b1;
    run_frame(tbl[7]);

    check("end_sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
